// File: rtl/fmbuf_pkg.sv
// fmbuf_pkg: shared bank-state type, default geometry and port-slice
// helpers for the ping-pong feature-map buffer.
package fmbuf_pkg;

    localparam int DW_D    = 16;
    localparam int DEPTH_D = 6144;
    localparam int AW_D    = 13;
    localparam int NPORT_D = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    function automatic int slice_lo(input int p, input int w);
        return p * w;
    endfunction

    function automatic logic can_write(input bank_state_e s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic can_read(input bank_state_e s);
        return (s == FULL) || (s == READING);
    endfunction

endpackage

// File: rtl/fmbuf_dpram.sv
// fmbuf_dpram: one write port, one registered read port.
// Contents are never cleared; read data holds when re is low.
module fmbuf_dpram
    import fmbuf_pkg::*;
#(
    parameter int DW    = DW_D,
    parameter int DEPTH = DEPTH_D,
    parameter int AW    = AW_D
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fmap_pingpong_mport_buf.sv
// Ping-pong feature-map store: one write stream, NPORT read ports.
// FMBUF_OUTREG_EN adds an output register stage (read latency 2).
module fmap_pingpong_mport_buf
    import fmbuf_pkg::*;
#(
    parameter int DW    = DW_D,
    parameter int DEPTH = DEPTH_D,
    parameter int AW    = AW_D,
    parameter int NPORT = NPORT_D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                wr_last,
    output logic                rd_bank_vld,
    input  logic [NPORT-1:0]    rd_en,
    input  logic [NPORT*AW-1:0] rd_addr,
    output logic [NPORT*DW-1:0] rd_data,
    output logic [NPORT-1:0]    rd_vld,
    input  logic                rd_release,
    output logic                err_addr,
    output logic                err_proto
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             init_q;
    logic             accept, wr_oor;
    logic [NPORT-1:0] rd_go, rd_oor;

    assign accept = wr_valid & wr_ready;
    assign wr_oor = {1'b0, wr_addr} >= DEPTH_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            init_q   <= 1'b1;
        end
    end

    // A bank is never writable and readable at once, so both ops can land together.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ (accept & wr_last);
        rd_ptr_d = rd_ptr_q ^ (rd_release & rd_bank_vld);
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (accept && wr_ptr_q == 1'(b))
                state_d[b] = wr_last ? FULL : FILLING;
            if (rd_bank_vld && rd_ptr_q == 1'(b)) begin
                if (rd_release)
                    state_d[b] = EMPTY;
                else if (state_q[b] == FULL && |rd_en)
                    state_d[b] = READING;
            end
        end
    end

    always_comb begin
        wr_ready    = init_q & can_write(state_q[wr_ptr_q]);
        rd_bank_vld = can_read(state_q[rd_ptr_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr  <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            err_addr  <= err_addr | (accept & wr_oor) | |(rd_go & rd_oor);
            err_proto <= err_proto | (rd_release & ~rd_bank_vld)
                                   | (wr_valid & ~wr_ready);
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [AW-1:0] ra;
        logic [DW-1:0] dout [2];
        logic [DW-1:0] d1;
        logic          vld_q, sel_q, zero_q;

        assign ra        = rd_addr[slice_lo(p, AW) +: AW];
        assign rd_oor[p] = {1'b0, ra} >= DEPTH_W;
        assign rd_go[p]  = rd_en[p] & rd_bank_vld;

        for (genvar b = 0; b < 2; b++) begin : g_bank
            fmbuf_dpram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
                .clk   (clk),
                .we    (accept & ~wr_oor & (wr_ptr_q == 1'(b))),
                .waddr (wr_addr),
                .wdata (wr_data),
                .re    (rd_go[p] & ~rd_oor[p] & (rd_ptr_q == 1'(b))),
                .raddr (ra),
                .rdata (dout[b])
            );
        end

        // zero_q resets high so rd_data reads 0 before any RAM read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                sel_q  <= 1'b0;
                zero_q <= 1'b1;
            end else begin
                vld_q <= rd_go[p];
                if (rd_go[p]) begin
                    sel_q  <= rd_ptr_q;
                    zero_q <= rd_oor[p];
                end
            end
        end

        assign d1 = zero_q ? '0 : dout[sel_q];

`ifdef FMBUF_OUTREG_EN
        logic          vld2_q;
        logic [DW-1:0] data2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                vld2_q <= vld_q;
                if (vld_q) data2_q <= d1;
            end
        end

        assign rd_vld[p]                     = vld2_q;
        assign rd_data[slice_lo(p, DW) +: DW] = data2_q;
`else
        assign rd_vld[p]                     = vld_q;
        assign rd_data[slice_lo(p, DW) +: DW] = d1;
`endif
    end

endmodule

// File: tb/tb_fmap_pingpong_mport_buf.sv
// Scoreboard bench for fmap_pingpong_mport_buf: randomized reads and fills
// against a bank-array model; a negedge monitor pops expected read data.
module tb_fmap_pingpong_mport_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 6144;
    localparam int AW    = 13;
    localparam int NP    = 5;
`ifdef FMBUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic             wr_last = 1'b0;
    logic             rd_release = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic [NP-1:0]    rd_en = '0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic             wr_ready, rd_bank_vld, err_addr, err_proto;
    logic [NP-1:0]    rd_vld;
    logic [NP*DW-1:0] rd_data;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    logic [DW-1:0] mem [2][DEPTH];
    bit            full [2];
    bit            wptr, rptr, init_done, e_addr, e_proto;
    exp_t          sbq [NP][$];

    fmap_pingpong_mport_buf dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_bank_vld(rd_bank_vld), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_vld(rd_vld), .rd_release(rd_release),
        .err_addr(err_addr), .err_proto(err_proto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [NP*DW-1:0] act,
                        input logic [NP*DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (rd_vld[p]) begin
                    nvec++;
                    if (sbq[p].size() == 0) begin
                        nerr++;
                        $display("FAIL rd_vld[%0d]: unexpected valid, data %0h (cycle %0d)",
                                 p, rd_data[p*DW +: DW], cyc);
                    end else begin
                        exp_t e;
                        e = sbq[p].pop_front();
                        if (rd_data[p*DW +: DW] !== e.d || cyc != e.due) begin
                            nerr++;
                            $display("FAIL rd_data[%0d]: got %0h at cycle %0d, expected %0h at cycle %0d",
                                     p, rd_data[p*DW +: DW], cyc, e.d, e.due);
                        end
                    end
                end else if (sbq[p].size() != 0 && sbq[p][0].due <= cyc) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rd_vld[%0d]: missing, expected %0h at cycle %0d",
                             p, sbq[p][0].d, sbq[p][0].due);
                    void'(sbq[p].pop_front());
                end
            end
        end
    end

    // One clock of stimulus: check status against the model, advance the model.
    task automatic apply();
        bit            rdy, bv;
        logic [AW-1:0] a;
        rdy = init_done && !full[wptr];
        bv  = full[rptr];
        chk1("wr_ready", wr_ready, rdy);
        chk1("rd_bank_vld", rd_bank_vld, bv);
        chk1("err_addr", err_addr, e_addr);
        chk1("err_proto", err_proto, e_proto);
        if (wr_valid) begin
            if (!rdy) begin
                e_proto = 1'b1;
            end else begin
                if (int'(wr_addr) < DEPTH) mem[wptr][wr_addr] = wr_data;
                else e_addr = 1'b1;
                if (wr_last) begin
                    full[wptr] = 1'b1;
                    wptr = !wptr;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (rd_en[p] && bv) begin
                exp_t e;
                a = rd_addr[p*AW +: AW];
                e.d   = (int'(a) < DEPTH) ? mem[rptr][a] : '0;
                e.due = cyc + LAT;
                if (int'(a) >= DEPTH) e_addr = 1'b1;
                sbq[p].push_back(e);
            end
        end
        if (rd_release) begin
            if (bv) begin
                full[rptr] = 1'b0;
                rptr = !rptr;
            end else begin
                e_proto = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        init_done = 1'b1;
    endtask

    task automatic rand_rd(input int lim);
        for (int p = 0; p < NP; p++) begin
            rd_en[p] = ($urandom_range(3) == 0);
            rd_addr[p*AW +: AW] = AW'($urandom_range(lim - 1));
        end
    endtask

    task automatic beat(input int addr, input int data, input bit last);
        while ($urandom_range(7) == 0) begin
            rand_rd(DEPTH);
            apply();
        end
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = DW'(data);
        wr_last  = last;
        rand_rd(DEPTH);
        apply();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_en    = '0;
    endtask

    task automatic fill(input int base, input bit rnd);
        for (int i = 0; i < DEPTH; i++)
            beat(i, rnd ? int'($urandom) : base + i, i == DEPTH - 1);
    endtask

    task automatic rd_fixed(input int base);
        rd_en = '1;
        for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'(base + p * 100);
        apply();
        rd_en = '0;
    endtask

    task automatic rand_phase(input int n, input int lim);
        for (int i = 0; i < n; i++) begin
            rand_rd(lim);
            apply();
        end
        rd_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk1("rst wr_ready", wr_ready, 1'b0);
        chk1("rst rd_bank_vld", rd_bank_vld, 1'b0);
        chkw("rst rd_vld", NP*DW'(rd_vld), '0);
        chkw("rst rd_data", rd_data, '0);
        chk1("rst err_addr", err_addr, 1'b0);
        chk1("rst err_proto", err_proto, 1'b0);
        wr_valid = 1'b0;
        wr_last = 1'b0;
        rd_en = '0;
        rd_release = 1'b0;
        for (int p = 0; p < NP; p++) sbq[p].delete();
        full[0] = 1'b0;
        full[1] = 1'b0;
        wptr = 1'b0;
        rptr = 1'b0;
        init_done = 1'b0;
        e_addr = 1'b0;
        e_proto = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply();
    endtask

    initial begin
        logic [AW-1:0] la;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // release with no bank available
        rd_release = 1'b1;
        apply();
        rd_release = 1'b0;
        apply();
        apply();
        do_reset();

        fill(10000, 1'b0);
        rd_fixed(0);
        apply();
        rand_phase(30, DEPTH);

        // second frame lands before the first is released
        fill(20000, 1'b0);
        beat(100, 16'hbeef, 1'b0);
        apply();

        // release together with a read of the released bank
        rd_release = 1'b1;
        rd_en[0] = 1'b1;
        rd_addr[0 +: AW] = AW'(7);
        apply();
        rd_release = 1'b0;
        rd_en = '0;
        rd_fixed(0);
        rand_phase(20, DEPTH);

        // short frame whose last beat coincides with a release
        for (int i = 0; i < 199; i++)
            beat($urandom_range(DEPTH - 1), $urandom, 1'b0);
        la = AW'($urandom_range(DEPTH - 1));
        wr_valid = 1'b1;
        wr_addr = la;
        wr_data = DW'($urandom);
        wr_last = 1'b1;
        rd_release = 1'b1;
        apply();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        rd_release = 1'b0;
        rd_en[1] = 1'b1;
        rd_addr[AW +: AW] = la;
        apply();
        rd_en = '0;
        rand_phase(20, DEPTH);

        // out-of-range write must not alias into the bank
        beat(7000, 16'h1234, 1'b0);
        beat(5, 16'h5555, 1'b1);
        apply();
        rd_release = 1'b1;
        apply();
        rd_release = 1'b0;
        rd_en[3] = 1'b1;
        rd_addr[3*AW +: AW] = AW'(856);
        apply();
        rd_en = '0;
        rand_phase(10, DEPTH);
        rd_release = 1'b1;
        apply();
        rd_release = 1'b0;
        apply();

        // reset in the middle of a frame, then a clean refill
        for (int i = 0; i < 3000; i++) beat(i, $urandom, 1'b0);
        do_reset();
        fill(0, 1'b1);
        rd_en = '1;
        for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'(p * 100);
        rd_addr[2*AW +: AW] = AW'(DEPTH);
        apply();
        rd_en = '0;
        rand_phase(30, DEPTH + 200);
        repeat (4) apply();

        for (int p = 0; p < NP; p++) begin
            nvec++;
            if (sbq[p].size() != 0) begin
                nerr++;
                $display("FAIL drain[%0d]: %0d reads outstanding, expected 0",
                         p, sbq[p].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
